// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Holds the entry layout, FSM encodings and the NOP used for faulting entries.
package ifetch_queue_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        IFQ_FETCH = 1'b0,
        IFQ_FLUSH = 1'b1
    } ifq_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
        logic            fault;
    } ifq_entry_t;

    function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] addr);
        return addr + 32'd4;
    endfunction

endpackage

// File: rtl/ifetch_queue_fifo.sv
// ifq_fifo: synchronous DEPTH-entry queue of fetch entries with count/full/empty and clear.
// Push into a full queue is accepted only when a pop frees the head in the same cycle.
module ifq_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  ifq_entry_t               wdata,
    input  logic                     pop,
    output ifq_entry_t               rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    ifq_entry_t    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    // Storage needs no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: fetch PC owner, imem request issue, response queueing and redirect flush.
// Optional misaligned-target faulting is enabled by defining IFQ_MISALIGN_EN.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        fetch_fault
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_X = (CW+1)'(DEPTH);

    ifq_state_e  state;
    ifq_state_e  state_next;
    logic [31:0] fetch_pc;
    logic [31:0] rsp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] drop_reload;
    logic [CW-1:0] fifo_count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    ifq_entry_t  fifo_wdata;
    ifq_entry_t  head;
    logic [31:0] target_pc;
    logic        misaligned;
    logic        halted;
    logic        fault_pend;
    logic        fault_push;
    logic        req_fire;
    logic        rsp_drop;
    logic        rsp_push;

`ifdef IFQ_MISALIGN_EN
    assign target_pc  = redirect_pc;
    assign misaligned = |redirect_pc[1:0];

    // A misaligned target halts fetch and injects one faulting NOP the cycle after the redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted     <= 1'b0;
            fault_pend <= 1'b0;
        end else begin
            fault_pend <= redirect_valid && misaligned;
            if (redirect_valid)
                halted <= misaligned;
        end
    end
`else
    logic unused_pc_lsb;
    assign unused_pc_lsb = ^redirect_pc[1:0];
    assign target_pc  = {redirect_pc[31:2], 2'b00};
    assign misaligned = 1'b0;
    assign halted     = 1'b0;
    assign fault_pend = 1'b0;
`endif

    assign imem_req_valid = !reset && !redirect_valid && !halted &&
                            (({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_X);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign drop_reload    = outstanding - {{(CW-1){1'b0}}, imem_rsp_valid};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IFQ_FETCH;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (redirect_valid)
            state_next = (drop_reload != '0) ? IFQ_FLUSH : IFQ_FETCH;
        else if (state == IFQ_FLUSH && imem_rsp_valid && drop_cnt == CW'(1))
            state_next = IFQ_FETCH;
    end

    always_comb begin
        rsp_drop = 1'b0;
        rsp_push = 1'b0;
        if (imem_rsp_valid) begin
            if (state == IFQ_FLUSH || redirect_valid)
                rsp_drop = 1'b1;
            else
                rsp_push = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding + {{(CW-1){1'b0}}, req_fire}
                                       - {{(CW-1){1'b0}}, imem_rsp_valid};
            if (redirect_valid) begin
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
                drop_cnt <= drop_reload;
            end else begin
                if (req_fire)
                    fetch_pc <= next_word(fetch_pc);
                if (rsp_push)
                    rsp_pc <= next_word(rsp_pc);
                if (rsp_drop && drop_cnt != '0)
                    drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    // rsp_pc equals the faulting target while a fault entry is pending.
    assign fault_push       = fault_pend && !redirect_valid;
    assign fifo_push        = rsp_push || fault_push;
    assign fifo_wdata.pc    = rsp_pc;
    assign fifo_wdata.data  = fault_push ? NOP_INSTR : imem_rsp_data;
    assign fifo_wdata.fault = fault_push;

    assign instr_valid = !fifo_empty && !redirect_valid;
    assign fifo_pop    = instr_valid && instr_ready;
    assign instr_data  = head.data;
    assign instr_pc    = head.pc;
    assign fetch_fault = head.fault;

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .clear (redirect_valid),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: memory model plus program-order expectation queue.
// Build with +define+IFQ_MISALIGN_EN to exercise misaligned-target faulting.
`timescale 1ns/1ps
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        fetch_fault;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } exp_t;
    typedef struct {
        logic [31:0] addr;
        int          ready;
    } mreq_t;

    exp_t        exp_q[$];
    mreq_t       mem_q[$];
    logic [31:0] req_next = 32'h0;
    bit          halted_m = 1'b0;
    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          ready_pct = 100;
    int          req_fires = 0;
    int          instr_fires = 0;
    bit          arm_first = 1'b0;
    logic [31:0] first_pc = 32'hdead_beef;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a3c, a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req)
            passes++;
        else
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        exp_q.delete();
`ifdef IFQ_MISALIGN_EN
        if (t[1:0] != 2'b00) begin
            halted_m = 1'b1;
            exp_q.push_back('{t, 32'h0000_0013, 1'b1});
        end else begin
            halted_m = 1'b0;
            req_next = t;
        end
`else
        halted_m = 1'b0;
        req_next = {t[31:2], 2'b00};
`endif
    endtask

    always @(posedge clk) cyc++;

    // Memory: in-order responses after a per-request latency, random request back-pressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                mem_q.delete();
                imem_rsp_valid = 1'b0;
                imem_req_ready = 1'b0;
            end else begin
                if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = memfn(mem_q[0].addr);
                    void'(mem_q.pop_front());
                end else begin
                    imem_rsp_valid = 1'b0;
                end
                imem_req_ready = ($urandom_range(99) < ready_pct);
            end
        end
    end

    // Monitor: requests feed the expectation queue, delivered instructions are checked against it.
    always @(negedge clk) begin
        if (!reset) begin
            if (redirect_valid)
                check("redirect_quiet", {30'b0, imem_req_valid, instr_valid}, 32'h0);
            if (instr_valid && instr_ready) begin
                instr_fires++;
                if (arm_first) begin
                    first_pc  = instr_pc;
                    arm_first = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_instr: got pc %h, want none (cycle %0d)", instr_pc, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("instr_pc", instr_pc, e.pc);
                    check("instr_data", instr_data, e.data);
                    check("instr_fault", {31'b0, fetch_fault}, {31'b0, e.fault});
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                req_fires++;
                if (halted_m) begin
                    checks++;
                    $display("FAIL req_while_halted: got req %h, want no request (cycle %0d)", imem_req_addr, cyc);
                end else begin
                    check("req_addr", imem_req_addr, req_next);
                    exp_q.push_back('{req_next, memfn(req_next), 1'b0});
                    req_next = req_next + 32'd4;
                end
                mem_q.push_back('{imem_req_addr, cyc + $urandom_range(lat_max, lat_min)});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        logic [31:0] t;

        #2;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_fault", {31'b0, fetch_fault}, 32'h0);
        tick();
        tick();
        check("rst_req_valid_hold", {31'b0, imem_req_valid}, 32'h0);
        reset = 1'b0;
        req_next = 32'h0;
        check("post_rst_instr_valid", {31'b0, instr_valid}, 32'h0);

        // Steady streaming at latency 1
        instr_ready = 1'b1;
        repeat (10) tick();
        base = instr_fires;
        repeat (20) tick();
        check("t1_throughput", 32'(instr_fires - base), 32'd20);

        // Decode stall: exactly DEPTH new-path requests
        instr_ready = 1'b0;
        do_redirect(32'h40);
        base = req_fires;
        tick();
        redirect_valid = 1'b0;
        repeat (15) tick();
        check("t2_req_count", 32'(req_fires - base), 32'd4);
        check("t2_req_stalled", {31'b0, imem_req_valid}, 32'h0);
        instr_ready = 1'b1;
        repeat (15) tick();

        // Redirect with long-latency requests in flight
        lat_min = 10;
        lat_max = 10;
        repeat (6) tick();
        do_redirect(32'h100);
        tick();
        redirect_valid = 1'b0;
        lat_min = 1;
        lat_max = 1;
        arm_first = 1'b1;
        first_pc = 32'hdead_beef;
        repeat (30) tick();
        check("t3_first_pc", first_pc, 32'h100);

        // Redirect colliding with a response and a pop
        do_redirect(32'h180);
        #1;
        check("t4_rsp_same_cycle", {31'b0, imem_rsp_valid}, 32'h1);
        check("t4_instr_valid", {31'b0, instr_valid}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        check("t4_empty_next", {31'b0, instr_valid}, 32'h0);
        repeat (10) tick();

        // Back-to-back redirects
        do_redirect(32'h200);
        tick();
        do_redirect(32'h300);
        tick();
        redirect_valid = 1'b0;
        arm_first = 1'b1;
        first_pc = 32'hdead_beef;
        repeat (20) tick();
        check("t5_first_pc", first_pc, 32'h300);

        // Misaligned target
        do_redirect(32'h102);
        tick();
        redirect_valid = 1'b0;
        arm_first = 1'b1;
        first_pc = 32'hdead_beef;
        base = req_fires;
        repeat (15) tick();
`ifdef IFQ_MISALIGN_EN
        check("t6_first_pc", first_pc, 32'h102);
        check("t6_halt_reqs", 32'(req_fires - base), 32'd0);
        check("t6_req_valid", {31'b0, imem_req_valid}, 32'h0);
`else
        check("t6_first_pc", first_pc, 32'h100);
`endif

        // Randomized traffic
        lat_min = 1;
        lat_max = 4;
        ready_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            instr_ready = ($urandom_range(99) < 70);
            if ($urandom_range(39) == 0) begin
                t = $urandom & 32'h0000_fffc;
                if ($urandom_range(3) == 0)
                    t[1:0] = 2'($urandom_range(3));
                do_redirect(t);
            end else begin
                redirect_valid = 1'b0;
            end
            tick();
        end

        // Return to clean streaming
        lat_min = 1;
        lat_max = 1;
        ready_pct = 100;
        instr_ready = 1'b1;
        do_redirect(32'h1000);
        tick();
        redirect_valid = 1'b0;
        repeat (20) tick();
        base = instr_fires;
        repeat (20) tick();
        check("final_throughput", 32'(instr_fires - base), 32'd20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
